// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// The operands are split into NB = WIDTH/BLOCK lookahead blocks, and block k
// is resolved in pipeline stage k. The block carry is registered between
// stages. Operand bits that have not been added yet move forward with each
// stage. Resolved sum bits are also carried forward, so that the whole result
// leaves the last stage aligned. A stall holds every stage at once, so bubbles
// are kept and result order is preserved.
module pipe_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int NB = WIDTH / BLOCK;
    localparam int NG = BLOCK / 4;
    localparam logic [WIDTH-1:0] SLICE_ONES = WIDTH'({BLOCK{1'b1}});

    if ((WIDTH % BLOCK) != 0) begin : g_width_check
        $error("pipe_cla_adder: WIDTH (%0d) is not a multiple of BLOCK (%0d)", WIDTH, BLOCK);
    end

    if ((BLOCK != 4) && (BLOCK != 8) && (BLOCK != 16) && (BLOCK != 32)) begin : g_block_check
        $error("pipe_cla_adder: BLOCK (%0d) must be 4, 8, 16 or 32", BLOCK);
    end

    // One BLOCK-bit lookahead adder.
    // It returns {carry into block MSB, block carry out, sum}.
    // Carries come from nibble generate/propagate terms, and group carries are
    // flattened sums of products. No carry ripples through more than 4 bits.
    function automatic logic [BLOCK+1:0] cla_block(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             cin
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] c;
        logic [NG-1:0]    gg;
        logic [NG-1:0]    gp;
        logic [NG:0]      gc;
        logic             acc;
        logic             pp;
        g = a & b;
        p = a ^ b;
        for (int j = 0; j < NG; j++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int i = 3; i >= 0; i--) begin
                acc = acc | (pp & g[4*j+i]);
                pp  = pp & p[4*j+i];
            end
            gg[j] = acc;
            gp[j] = pp;
        end
        gc[0] = cin;
        for (int j = 1; j <= NG; j++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                acc = acc | (pp & gg[i]);
                pp  = pp & gp[i];
            end
            gc[j] = acc | (pp & cin);
        end
        for (int j = 0; j < NG; j++) begin
            for (int m = 0; m < 4; m++) begin
                acc = 1'b0;
                pp  = 1'b1;
                for (int i = m - 1; i >= 0; i--) begin
                    acc = acc | (pp & g[4*j+i]);
                    pp  = pp & p[4*j+i];
                end
                c[4*j+m] = acc | (pp & gc[j]);
            end
        end
        return {c[BLOCK-1], gc[NG], p ^ c};
    endfunction

    logic             adv_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;
    logic [WIDTH-1:0] stg_a_s   [NB];
    logic [WIDTH-1:0] stg_b_s   [NB];
    logic             stg_c_s   [NB];
    logic [WIDTH-1:0] stg_acc_s [NB];
    logic [BLOCK+1:0] blk_s     [NB];
    logic [WIDTH-1:0] sum_nxt_s [NB];

    logic             valid_r [NB];
    logic             carry_r [NB];
    logic [WIDTH-1:0] a_r     [NB];
    logic [WIDTH-1:0] b_r     [NB];
    logic [WIDTH-1:0] sum_r   [NB];
    logic             ovf_r;

    // The pipeline moves as one unit. It advances unless a finished result is
    // still waiting at the output.
    assign adv_s    = ~valid_r[NB-1] | out_ready;
    assign in_ready = adv_s;

    // Subtract is A + ~B + 1. The external carry-in is ignored in that mode.
    assign b_eff_s = in_sub ? ~in_b : in_b;
    assign c0_s    = in_sub ? 1'b1 : in_cin;

    for (genvar k = 0; k < NB; k++) begin : g_stage
        if (k == 0) begin : g_src
            assign stg_a_s[k]   = in_a;
            assign stg_b_s[k]   = b_eff_s;
            assign stg_c_s[k]   = c0_s;
            assign stg_acc_s[k] = {WIDTH{1'b0}};
        end else begin : g_src
            assign stg_a_s[k]   = a_r[k-1];
            assign stg_b_s[k]   = b_r[k-1];
            assign stg_c_s[k]   = carry_r[k-1];
            assign stg_acc_s[k] = sum_r[k-1];
        end

        assign blk_s[k] = cla_block(stg_a_s[k][k*BLOCK +: BLOCK],
                                    stg_b_s[k][k*BLOCK +: BLOCK],
                                    stg_c_s[k]);

        // Put this stage's sum slice into the partial result it received.
        assign sum_nxt_s[k] = (stg_acc_s[k] & ~(SLICE_ONES << (k*BLOCK)))
                            | (WIDTH'(blk_s[k][BLOCK-1:0]) << (k*BLOCK));
    end

    // Stage registers: all stages shift together on advance and hold together on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NB; k++) begin
                valid_r[k] <= 1'b0;
                carry_r[k] <= 1'b0;
                a_r[k]     <= {WIDTH{1'b0}};
                b_r[k]     <= {WIDTH{1'b0}};
                sum_r[k]   <= {WIDTH{1'b0}};
            end
            ovf_r <= 1'b0;
        end else if (adv_s) begin
            valid_r[0] <= in_valid;
            for (int k = 1; k < NB; k++) begin
                valid_r[k] <= valid_r[k-1];
            end
            for (int k = 0; k < NB; k++) begin
                carry_r[k] <= blk_s[k][BLOCK];
                a_r[k]     <= stg_a_s[k];
                b_r[k]     <= stg_b_s[k];
                sum_r[k]   <= sum_nxt_s[k];
            end
            // Overflow is the carry into the MSB XOR the carry out of it,
            // both taken from the final block.
            ovf_r <= blk_s[NB-1][BLOCK+1] ^ blk_s[NB-1][BLOCK];
        end
    end

    assign out_valid = valid_r[NB-1];
    assign out_sum   = sum_r[NB-1];
    assign out_cout  = carry_r[NB-1];
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Bench for pipe_cla_adder at three sizes: (32,16), (8,8) and (64,16).
// The three instances share one stimulus stream. Each instance has its own
// cycle-level pipeline model that tracks latency, stalls and bubbles.
module tb_pipe_cla_adder;

    localparam int LAT [3] = '{2, 1, 4};
    localparam int WID [3] = '{32, 8, 64};

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_cin;
    logic        in_sub;
    logic        out_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;

    logic        rdy_32, rdy_8, rdy_64;
    logic        ov_32, ov_8, ov_64;
    logic [31:0] sum_32;
    logic [7:0]  sum_8;
    logic [63:0] sum_64;
    logic        co_32, co_8, co_64;
    logic        of_32, of_8, of_64;

    int          n_run;
    int          n_fail;

    // Model state per instance.
    // mv holds the valid bit of each stage.
    // md holds {ovf, cout, sum} for each stage.
    logic        mv [3][4];
    logic [65:0] md [3][4];

    pipe_cla_adder #(.WIDTH(32), .BLOCK(16)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_32),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(ov_32), .out_ready(out_ready), .out_sum(sum_32),
        .out_cout(co_32), .out_ovf(of_32)
    );

    pipe_cla_adder #(.WIDTH(8), .BLOCK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_8),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(ov_8), .out_ready(out_ready), .out_sum(sum_8),
        .out_cout(co_8), .out_ovf(of_8)
    );

    pipe_cla_adder #(.WIDTH(64), .BLOCK(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_64),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(ov_64), .out_ready(out_ready), .out_sum(sum_64),
        .out_cout(co_64), .out_ovf(of_64)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Pack a hand-computed 32-bit result into the model's {ovf, cout, sum} layout.
    function automatic logic [65:0] mk(input logic ovf, input logic cout, input logic [31:0] s);
        return {ovf, cout, 32'h0, s};
    endfunction

    // Arithmetic reference at width w. Overflow uses the sign rule: both
    // addends have the same sign and the sum sign differs from them.
    function automatic logic [65:0] ref_calc(input int w, input logic [63:0] a, input logic [63:0] b,
                                             input logic cin, input logic sub);
        logic [64:0] mask;
        logic [64:0] aa;
        logic [64:0] bb;
        logic [64:0] t;
        logic [63:0] s;
        logic        c;
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, a} & mask;
        bb   = {1'b0, (sub ? ~b : b)} & mask;
        c    = sub ? 1'b1 : cin;
        t    = aa + bb + {64'd0, c};
        s    = t[63:0] & mask[63:0];
        return {((aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1])), t[w], s};
    endfunction

    task automatic get_out(input int d, output logic v, output logic r, output logic [65:0] res);
        case (d)
            0: begin v = ov_32; r = rdy_32; res = {of_32, co_32, 32'h0, sum_32}; end
            1: begin v = ov_8;  r = rdy_8;  res = {of_8, co_8, 56'h0, sum_8};    end
            2: begin v = ov_64; r = rdy_64; res = {of_64, co_64, sum_64};        end
            default: begin v = 1'b0; r = 1'b0; res = 66'd0; end
        endcase
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) begin
                mv[d][k] = 1'b0;
                md[d][k] = 66'd0;
            end
        end
    endtask

    // One clock cycle, entered and left at a negative edge. The task:
    //  1. checks the outputs against the model;
    //  2. drives new inputs and checks in_ready;
    //  3. advances the model as the DUT will at the next rising edge.
    task automatic cycle(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub, input logic rdy,
                         input logic has_exp, input logic [65:0] exp32);
        logic        ov;
        logic        ir;
        logic [65:0] res;
        logic        exp_ir;
        for (int d = 0; d < 3; d++) begin
            get_out(d, ov, ir, res);
            check_eq($sformatf("out_valid w%0d", WID[d]), {65'd0, ov}, {65'd0, mv[d][LAT[d]-1]});
            if (mv[d][LAT[d]-1]) begin
                check_eq($sformatf("result w%0d", WID[d]), res, md[d][LAT[d]-1]);
            end
        end
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        out_ready = rdy;
        #1;
        for (int d = 0; d < 3; d++) begin
            get_out(d, ov, ir, res);
            exp_ir = !mv[d][LAT[d]-1] || rdy;
            check_eq($sformatf("in_ready w%0d", WID[d]), {65'd0, ir}, {65'd0, exp_ir});
            if (exp_ir) begin
                for (int k = LAT[d] - 1; k > 0; k--) begin
                    mv[d][k] = mv[d][k-1];
                    md[d][k] = md[d][k-1];
                end
                mv[d][0] = v;
                md[d][0] = (d == 0 && has_exp) ? exp32 : ref_calc(WID[d], a, b, cin, sub);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 66'd0);
        end
    endtask

    // Assert reset at a negative edge and check that the outputs clear at
    // once, without waiting for a clock edge. Release at the next negative edge.
    task automatic pulse_reset();
        logic        ov;
        logic        ir;
        logic [65:0] res;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            get_out(d, ov, ir, res);
            check_eq($sformatf("reset out_valid w%0d", WID[d]), {65'd0, ov}, 66'd0);
            check_eq($sformatf("reset result w%0d", WID[d]), res, 66'd0);
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        n_run     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 64'd0;
        in_b      = 64'd0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        clear_model();
        @(negedge clk);
        pulse_reset();

        // Isolated vectors. The model checks exact latency and each result.
        cycle(1'b1, 64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b1, 32'h00000000));
        idle(4);
        cycle(1'b1, 64'h5, 64'h7, 1'b1, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b0, 32'hFFFFFFFE));
        idle(3);
        cycle(1'b1, 64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 1'b1, 1'b1, mk(1'b1, 1'b0, 32'h80000000));
        cycle(1'b1, 64'h80000000, 64'h1, 1'b0, 1'b1, 1'b1, 1'b1, mk(1'b1, 1'b1, 32'h7FFFFFFF));
        cycle(1'b1, 64'hFFFF0000, 64'h0000FFFF, 1'b1, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b1, 32'h00000000));
        idle(4);

        // Four back-to-back ops, then a three-cycle stall with new ops offered.
        cycle(1'b1, 64'h12345678, 64'h9ABCDEF0, 1'b0, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 32'hACF13568));
        cycle(1'b1, 64'h0000FFFF, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 32'h00010000));
        cycle(1'b1, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b1, 32'h00000000));
        cycle(1'b1, 64'h0, 64'h80000000, 1'b0, 1'b1, 1'b1, 1'b1, mk(1'b1, 1'b0, 32'h80000000));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 64'h1, 64'h1, 1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 32'h00000002));
        end
        idle(5);

        // Two ops in flight, then a reset. Nothing may emerge after release,
        // and the next op must keep normal latency.
        cycle(1'b1, 64'h11111111, 64'h22222222, 1'b0, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 32'h33333333));
        cycle(1'b1, 64'h44444444, 64'h11111111, 1'b0, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b1, 32'h33333333));
        pulse_reset();
        idle(4);
        cycle(1'b1, 64'h00000010, 64'h00000020, 1'b1, 1'b0, 1'b1, 1'b1, mk(1'b0, 1'b0, 32'h00000031));
        idle(5);

        // Random operands with random valid and ready against the arithmetic reference.
        for (int n = 0; n < 3000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) begin
                ra = 64'hFFFFFFFFFFFFFFFF;
            end
            if ($urandom_range(0, 7) == 0) begin
                rb = {32'h0, $urandom_range(0, 3)};
            end
            cycle($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'b0, 66'd0);
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
